// File: rtl/dmem_dma_arbiter_pkg.sv
// Shared constants and state encoding for the data-bus DMA arbiter.
package dmem_dma_arbiter_pkg;

    localparam logic [15:0] DMEM_LO = 16'h0000;
    localparam logic [15:0] DMEM_HI = 16'h07FF;
    localparam logic [15:0] VMEM_LO = 16'h2000;
    localparam logic [15:0] VMEM_HI = 16'h2960;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_CAPTURE,
        ST_WR_WAIT
    } dma_state_e;

endpackage

// File: rtl/dmem_dma_arbiter_range_check.sv
// Flags a block copy whose source leaves data RAM or whose
// destination leaves video RAM.
module dma_range_check
    import dmem_dma_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 12
) (
    input  logic [ADDR_W-1:0] src,
    input  logic [ADDR_W-1:0] dst,
    input  logic [LEN_W-1:0]  len,
    output logic              range_err
);

    localparam int W = ADDR_W + 1;

    logic [W-1:0] len_x;
    logic [W-1:0] src_end;
    logic [W-1:0] dst_end;

    // One extra bit keeps a wrap past the top of the address space visible.
    always_comb begin
        len_x     = W'(len);
        src_end   = {1'b0, src} + len_x - W'(1);
        dst_end   = {1'b0, dst} + len_x - W'(1);
        range_err = (src_end > W'(DMEM_HI))
                 || (dst < ADDR_W'(VMEM_LO))
                 || (dst_end > W'(VMEM_HI));
    end

endmodule

// File: rtl/dmem_dma_arbiter.sv
// CPU/DMA bus arbiter: the CPU owns the bus combinationally, the DMA
// copies bytes from data RAM to video RAM in cycles the CPU leaves idle.
module dmem_dma_arbiter
    import dmem_dma_arbiter_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_w_en,
    input  logic              cpu_r_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_w_en,
    output logic              bus_r_en,
    input  logic [DATA_W-1:0] dmem_dout,
    input  logic              cfg_start,
    input  logic              cfg_abort,
    input  logic [ADDR_W-1:0] cfg_src,
    input  logic [ADDR_W-1:0] cfg_dst,
    input  logic [LEN_W-1:0]  cfg_len,
    output logic              busy,
    output logic              done,
    output logic              err
);

    dma_state_e        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              cpu_r_en_q;

    logic free;
    logic dma_rd;
    logic dma_wr;
    logic range_err;

    dma_range_check #(
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_range_check (
        .src      (cfg_src),
        .dst      (cfg_dst),
        .len      (cfg_len),
        .range_err(range_err)
    );

    // The cycle after a CPU read is reserved: decode returns data by address.
    always_comb begin
        free   = !cpu_w_en && !cpu_r_en && !cpu_r_en_q;
        dma_rd = free && !cfg_abort && (state_q == ST_RD_WAIT);
        dma_wr = free && !cfg_abort && (state_q == ST_WR_WAIT);
    end

    always_comb begin
        bus_addr  = cpu_addr;
        bus_wdata = cpu_wdata;
        bus_w_en  = cpu_w_en;
        bus_r_en  = cpu_r_en;
        unique case (1'b1)
            dma_rd: begin
                bus_addr = src_q;
                bus_r_en = 1'b1;
            end
            dma_wr: begin
                bus_addr  = dst_q;
                bus_wdata = data_q;
                bus_w_en  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    src_d = cfg_src;
                    dst_d = cfg_dst;
                    rem_d = cfg_len;
                    if (cfg_len == '0) begin
                        done_d = 1'b1;
                        err_d  = 1'b0;
                    end else if (range_err) begin
                        err_d = 1'b1;
                    end else begin
                        err_d   = 1'b0;
                        busy_d  = 1'b1;
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (dma_rd) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                data_d  = dmem_dout;
                state_d = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                if (dma_wr) begin
                    src_d = src_q + ADDR_W'(1);
                    dst_d = dst_q + ADDR_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_RD_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            cpu_r_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            rem_q      <= rem_d;
            data_q     <= data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            cpu_r_en_q <= cpu_r_en;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dmem_dma_arbiter.sv
// Directed bench for dmem_dma_arbiter with a small d_ram model and
// a log of every bus write.
module tb_dmem_dma_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_w_en;
    logic        cpu_r_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_w_en;
    logic        bus_r_en;
    logic [7:0]  dmem_dout = 8'h00;
    logic        cfg_start;
    logic        cfg_abort;
    logic [15:0] cfg_src;
    logic [15:0] cfg_dst;
    logic [11:0] cfg_len;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  dmem [0:2047];
    logic [15:0] wa_q [$];
    logic [7:0]  wd_q [$];
    logic        rd_pend = 1'b0;
    logic [15:0] rd_addr = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    int bcnt;
    bit seen;

    always #5 clk = ~clk;

    dmem_dma_arbiter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_w_en (cpu_w_en),
        .cpu_r_en (cpu_r_en),
        .bus_addr (bus_addr),
        .bus_wdata(bus_wdata),
        .bus_w_en (bus_w_en),
        .bus_r_en (bus_r_en),
        .dmem_dout(dmem_dout),
        .cfg_start(cfg_start),
        .cfg_abort(cfg_abort),
        .cfg_src  (cfg_src),
        .cfg_dst  (cfg_dst),
        .cfg_len  (cfg_len),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    // Bus sampled mid-cycle; d_ram answers a read one edge later.
    always @(negedge clk) begin
        if (rst_n && bus_w_en) begin
            wa_q.push_back(bus_addr);
            wd_q.push_back(bus_wdata);
        end
        rd_pend = rst_n && bus_r_en;
        rd_addr = bus_addr;
    end

    always @(posedge clk) begin
        if (rd_pend && rd_addr < 16'h0800) dmem_dout <= dmem[rd_addr[10:0]];
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [15:0] s, input logic [15:0] d,
                         input logic [11:0] l);
        cfg_src   = s;
        cfg_dst   = d;
        cfg_len   = l;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_done(input int max, output int c, output int b,
                             output bit s);
        c = 0;
        b = 0;
        s = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (done) begin
                s = 1'b1;
                break;
            end
            if (busy) b++;
            c++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_wr(input string tag, input int i,
                            input logic [15:0] a, input logic [7:0] d);
        if (i < wa_q.size()) begin
            check({tag, "_addr"}, 32'(wa_q[i]), 32'(a));
            check({tag, "_data"}, 32'(wd_q[i]), 32'(d));
        end else begin
            check({tag, "_count"}, wa_q.size(), i + 1);
        end
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 2048; i++) dmem[i] = 8'(i) ^ 8'h5A;
        dmem[16'h10] = 8'hA1;
        dmem[16'h11] = 8'hB2;
        dmem[16'h12] = 8'hC3;
        dmem[16'h13] = 8'hD4;
        dmem[16'h20] = 8'h5A;
        dmem[16'h21] = 8'h6B;
        dmem[16'h30] = 8'h77;
        dmem[16'h40] = 8'h99;
        dmem[16'h7FF] = 8'hE7;

        rst_n     = 1'b0;
        cpu_addr  = 16'h1234;
        cpu_wdata = 8'h00;
        cpu_w_en  = 1'b0;
        cpu_r_en  = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        cfg_src   = '0;
        cfg_dst   = '0;
        cfg_len   = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_bus_addr", 32'(bus_addr), 32'h1234);
        check("rst_bus_w_en", 32'(bus_w_en), 0);
        rst_n = 1'b1;
        tick();

        // Idle CPU, four bytes at full rate.
        clear_log();
        start(16'h0010, 16'h2000, 12'd4);
        wait_done(40, cyc, bcnt, seen);
        check("t1_done_seen", 32'(seen), 1);
        check("t1_done_cycle", cyc, 12);
        check("t1_busy_cycles", bcnt, 12);
        check("t1_busy_at_done", 32'(busy), 0);
        tick();
        @(negedge clk);
        check("t1_done_pulse", 32'(done), 0);
        check("t1_wr_count", wa_q.size(), 4);
        check_wr("t1_wr0", 0, 16'h2000, 8'hA1);
        check_wr("t1_wr1", 1, 16'h2001, 8'hB2);
        check_wr("t1_wr2", 2, 16'h2002, 8'hC3);
        check_wr("t1_wr3", 3, 16'h2003, 8'hD4);
        tick();

        // CPU writes every cycle: DMA gets nothing until it stops.
        clear_log();
        start(16'h0020, 16'h295F, 12'd2);
        for (int i = 0; i < 10; i++) begin
            cpu_w_en  = 1'b1;
            cpu_addr  = 16'h3000 + 16'(i);
            cpu_wdata = 8'h40 + 8'(i);
            tick();
        end
        cpu_w_en = 1'b0;
        cpu_addr = 16'h1234;
        @(negedge clk);
        check("t2_busy_held", 32'(busy), 1);
        check("t2_cpu_count", wa_q.size(), 10);
        for (int i = 0; i < 10; i++)
            check_wr("t2_cpu", i, 16'h3000 + 16'(i), 8'h40 + 8'(i));
        tick();
        wait_done(40, cyc, bcnt, seen);
        check("t2_done_seen", 32'(seen), 1);
        check("t2_wr_count", wa_q.size(), 12);
        check_wr("t2_dma0", 10, 16'h295F, 8'h5A);
        check_wr("t2_dma1", 11, 16'h2960, 8'h6B);
        tick();

        // CPU read during CAPTURE; its return cycle is protected.
        clear_log();
        start(16'h0030, 16'h2010, 12'd1);
        tick();
        cpu_r_en = 1'b1;
        cpu_addr = 16'h0040;
        @(negedge clk);
        check("t3_cpu_r_en", 32'(bus_r_en), 1);
        check("t3_cpu_raddr", 32'(bus_addr), 32'h0040);
        tick();
        cpu_r_en = 1'b0;
        @(negedge clk);
        check("t3_cpu_rdata", 32'(dmem_dout), 32'h99);
        check("t3_hold_w_en", 32'(bus_w_en), 0);
        check("t3_hold_addr", 32'(bus_addr), 32'h0040);
        tick();
        cpu_addr = 16'h1234;
        wait_done(20, cyc, bcnt, seen);
        check("t3_done_seen", 32'(seen), 1);
        check("t3_wr_delay", cyc, 1);
        check("t3_wr_count", wa_q.size(), 1);
        check_wr("t3_wr0", 0, 16'h2010, 8'h77);
        tick();

        // Range errors, then a valid start at both region tops.
        clear_log();
        start(16'h07FE, 16'h2000, 12'd4);
        @(negedge clk);
        check("t4_src_err", 32'(err), 1);
        check("t4_src_busy", 32'(busy), 0);
        tick();
        start(16'h0000, 16'h1FFF, 12'd1);
        @(negedge clk);
        check("t4_dst_lo_err", 32'(err), 1);
        tick();
        start(16'h0000, 16'hFFFF, 12'd2);
        @(negedge clk);
        check("t4_dst_wrap_err", 32'(err), 1);
        tick();
        repeat (3) tick();
        check("t4_no_write", wa_q.size(), 0);
        check("t4_busy_idle", 32'(busy), 0);
        start(16'h07FF, 16'h2960, 12'd1);
        @(negedge clk);
        check("t4_err_clear", 32'(err), 0);
        check("t4_busy_set", 32'(busy), 1);
        tick();
        wait_done(20, cyc, bcnt, seen);
        check("t4_done_seen", 32'(seen), 1);
        check("t4_wr_count", wa_q.size(), 1);
        check_wr("t4_wr0", 0, 16'h2960, 8'hE7);
        tick();

        // Zero length, then a start while busy.
        clear_log();
        start(16'h0040, 16'h2000, 12'd0);
        @(negedge clk);
        check("t5_len0_done", 32'(done), 1);
        check("t5_len0_busy", 32'(busy), 0);
        tick();
        @(negedge clk);
        check("t5_len0_pulse", 32'(done), 0);
        tick();
        start(16'h0010, 16'h2000, 12'd2);
        start(16'h0020, 16'h2100, 12'd3);
        wait_done(40, cyc, bcnt, seen);
        check("t5_done_seen", 32'(seen), 1);
        check("t5_done_cycle", cyc, 5);
        check("t5_wr_count", wa_q.size(), 2);
        check_wr("t5_wr0", 0, 16'h2000, 8'hA1);
        check_wr("t5_wr1", 1, 16'h2001, 8'hB2);
        repeat (8) tick();
        check("t5_no_extra", wa_q.size(), 2);
        check("t5_idle", 32'(busy), 0);

        // Abort in WR_WAIT of byte 2.
        clear_log();
        start(16'h0010, 16'h2004, 12'd3);
        repeat (5) tick();
        cfg_abort = 1'b1;
        @(negedge clk);
        check("t6_abort_w_en", 32'(bus_w_en), 0);
        tick();
        cfg_abort = 1'b0;
        @(negedge clk);
        check("t6_abort_busy", 32'(busy), 0);
        tick();
        wait_done(10, cyc, bcnt, seen);
        check("t6_no_done", 32'(seen), 0);
        check("t6_wr_count", wa_q.size(), 1);
        check_wr("t6_wr0", 0, 16'h2004, 8'hA1);
        tick();

        // Reset mid-transfer, in the first write cycle.
        clear_log();
        start(16'h0010, 16'h2008, 12'd4);
        repeat (2) tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("t7_busy", 32'(busy), 0);
        check("t7_done", 32'(done), 0);
        check("t7_err", 32'(err), 0);
        check("t7_w_en", 32'(bus_w_en), 0);
        check("t7_bus_addr", 32'(bus_addr), 32'h1234);
        tick();
        rst_n = 1'b1;
        repeat (6) tick();
        check("t7_no_write", wa_q.size(), 0);
        check("t7_idle", 32'(busy), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_dma_arbiter.md
Name: dmem_dma_arbiter

Overview:
- Arbitrates the 16-bit-address, 8-bit-data memory/IO bus between the CPU and a block-copy DMA engine.
- The DMA engine copies bytes from data RAM (0x0000–0x07FF) into video RAM (0x2000–0x2960), for example to redraw screen text without CPU load/store loops.
- Sits between the CPU data port and the address-decode/memory-map logic. It only steals bus cycles the CPU leaves idle, so the CPU never stalls.

Parameters:
- ADDR_W, 16, bus address width
- DATA_W, 8, bus data width
- LEN_W, 12, transfer length counter width (max 2048 bytes used)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_addr  in  ADDR_W  CPU data address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_w_en  in  1  CPU write strobe
- cpu_r_en  in  1  CPU read strobe
- bus_addr  out  ADDR_W  address to memory-map decode
- bus_wdata  out  DATA_W  write data to D_MEM/IO/V_MEM
- bus_w_en  out  1  write strobe to decode
- bus_r_en  out  1  read strobe to decode
- dmem_dout  in  DATA_W  raw d_ram read data (undecoded; updates only on a d_ram read)
- cfg_start  in  1  one-cycle start pulse
- cfg_abort  in  1  one-cycle abort pulse
- cfg_src  in  ADDR_W  source start address
- cfg_dst  in  ADDR_W  destination start address
- cfg_len  in  LEN_W  byte count
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion (usable as an interrupt)
- err  out  1  sticky range error; cleared by the next accepted cfg_start

Behaviour:
- Reset:
  - state=IDLE; busy=0, done=0, err=0.
  - Internal src/dst/remaining counters and data latch = 0; cpu_r_en_q = 0.
  - bus_* follow the CPU combinationally.
- Ownership:
  - The CPU always has priority and its path to the bus is combinational (0-cycle latency).
  - free = !cpu_w_en && !cpu_r_en && !cpu_r_en_q.
  - cpu_r_en_q is cpu_r_en registered. It protects the CPU read-return cycle, because decode muxes read data by the current address.
  - The DMA drives bus_* only in a cycle where free=1 and the state is RD_WAIT or WR_WAIT; otherwise bus_* = CPU signals.
- FSM states: IDLE, RD_WAIT, CAPTURE, WR_WAIT.
- IDLE:
  - On cfg_start, latch src/dst/len.
  - If len==0: pulse done next cycle, no bus activity, stay IDLE.
  - Else if src+len-1 > 0x07FF or dst < 0x2000 or dst+len-1 > 0x2960: set err=1, stay IDLE, no bus activity.
  - Else clear err, set busy=1, go to RD_WAIT.
  - Range arithmetic uses ADDR_W+1 bits so overflow cannot alias.
- RD_WAIT: when free, drive bus_addr=src, bus_r_en=1, then go to CAPTURE. Otherwise hold.
- CAPTURE:
  - Unconditionally latch dmem_dout at the end of this cycle; d_ram has one-cycle read latency.
  - A CPU read in this same cycle does not corrupt the latched value.
  - Go to WR_WAIT.
- WR_WAIT:
  - When free, drive bus_addr=dst, bus_wdata=latch, bus_w_en=1.
  - At the same edge: src+=1, dst+=1, remaining-=1.
  - If remaining was 1: go to IDLE, busy=0, done=1 for one cycle. Otherwise go to RD_WAIT.
- Throughput: 3 cycles/byte minimum when the CPU is idle.
- cfg_start while busy: ignored.
- cfg_abort while busy:
  - Next state is IDLE and busy=0; no done, err unchanged.
  - If abort arrives in CAPTURE or WR_WAIT, the pending byte is not written.
  - If cfg_abort and cfg_start arrive in the same cycle while busy: abort wins, start is ignored.
- Reset asserted mid-transfer: immediately returns to reset state; any pending byte is dropped.

Decomposition:
- Shared package holds:
  - Region constants: DMEM_LO=0x0000, DMEM_HI=0x07FF, VMEM_LO=0x2000, VMEM_HI=0x2960.
  - The FSM state encoding.
- One natural sub-module, dma_range_check: combinational, computes err from src/dst/len. Everything else stays in one module.

Test Plan:
- CPU idle; src=0x0010, dst=0x2000, len=4; dmem[0x10..0x13]=A1,B2,C3,D4 → writes A1..D4 to 0x2000..0x2003; done pulses exactly 12 cycles after start; busy high for those 12 cycles.
- CPU writes every cycle during a len=2 transfer → zero DMA bus cycles. CPU stops → transfer completes; every CPU write reaches the bus unmodified.
- CPU read issued in the cycle DMA was in CAPTURE → DMA byte is correct, CPU gets its own read data next cycle, and DMA holds off that return cycle.
- src=0x07FE, len=4 → err=1, no bus_w_en, busy stays 0. Then a valid start → err clears.
- len=0 → done pulses next cycle with no bus activity. A start while busy is ignored (counters unchanged).
- cfg_abort in WR_WAIT of byte 2 of len=3 → only byte 1 written, busy=0, no done. Reset asserted mid-transfer → all outputs return to reset values.
